// File: rtl/proc_ctrl_fsm.sv
// Multi-cycle control unit for the simple processor datapath.
// Steps each instruction through fetch, decode, execute, write-back and PC reload,
// skipping steps an opcode does not need and flagging illegal opcodes.
// Optional memory wait-state handshake in the execute step: define CTRL_MEMWAIT_EN.
module proc_ctrl_fsm #(
  parameter int unsigned DATA_W = 10,
  parameter int unsigned OPC_W  = 4,
  parameter int unsigned REG_AW = 3,
  parameter int unsigned PC_IDX = 2**REG_AW-1
) (
  input  logic              Clock,
  input  logic              reset,
  input  logic              run,
  input  logic [DATA_W-1:0] data,
  input  logic              mem_ready,
  output logic              done,
  output logic              incr_pc,
  output logic              WrRegisterBank,
  output logic              WrIR,
  output logic              WrW,
  output logic              WrDataOut,
  output logic              WrAddressOut,
  output logic              WrA,
  output logic              WrG,
  output logic [2:0]        multControl,
  output logic [REG_AW-1:0] addrRegisterBank,
  output logic [2:0]        aluControl,
  output logic              illegal
);

  localparam logic [2:0] MuxDin = 3'd1;
  localparam logic [2:0] MuxRb  = 3'd2;
  localparam logic [2:0] MuxAlu = 3'd4;

  localparam logic [OPC_W-1:0] OpMvi     = OPC_W'(8);
  localparam logic [OPC_W-1:0] OpSd      = OPC_W'(9);
  localparam logic [OPC_W-1:0] OpLd      = OPC_W'(10);
  localparam logic [OPC_W-1:0] OpIllegal = OPC_W'(11);

  localparam logic [REG_AW-1:0] PcAddr = REG_AW'(PC_IDX);

  typedef enum logic [2:0] {StFetch, StDec, StExec, StWb, StDone} state_e;

  state_e state_q, state_d;

  logic [OPC_W-1:0]  opcode;
  logic [REG_AW-1:0] rx, ry;
  logic              is_alu, is_mvi, is_ld, is_sd, is_ill;
  logic              mem_ok;

  // Fields are positional; bits between opcode and Rx are don't-care.
  assign opcode = data[DATA_W-1 -: OPC_W];
  assign rx     = data[2*REG_AW-1:REG_AW];
  assign ry     = data[REG_AW-1:0];

  assign is_alu = (opcode < OpMvi);
  assign is_mvi = (opcode == OpMvi);
  assign is_sd  = (opcode == OpSd);
  assign is_ld  = (opcode == OpLd);
  assign is_ill = (opcode >= OpIllegal);

`ifdef CTRL_MEMWAIT_EN
  // Memory ops leave execute only once the access has completed.
  assign mem_ok = is_alu || mem_ready;
`else
  logic unused_mem_ready;
  assign unused_mem_ready = mem_ready;
  assign mem_ok = 1'b1;
`endif

  logic unused_data;
  assign unused_data = ^data;

  // State register; asynchronous reset restarts at fetch.
  always_ff @(posedge Clock or posedge reset) begin
    if (reset) state_q <= StFetch;
    else       state_q <= state_d;
  end

  // Next-state: hold while run is low, except the done step always returns to fetch.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StFetch: if (run) state_d = StDec;
      StDec:   if (run) state_d = is_ill ? StDone : StExec;
      StExec:  if (run && mem_ok) state_d = is_alu ? StWb : StDone;
      StWb:    if (run) state_d = StDone;
      StDone:  state_d = StFetch;
      default: state_d = StFetch;
    endcase
  end

  // Output decode of state and instruction; everything idles while reset is high.
  always_comb begin
    done             = 1'b0;
    incr_pc          = 1'b0;
    WrRegisterBank   = 1'b0;
    WrIR             = 1'b0;
    WrW              = 1'b0;
    WrDataOut        = 1'b0;
    WrAddressOut     = 1'b0;
    WrA              = 1'b0;
    WrG              = 1'b0;
    multControl      = MuxRb;
    addrRegisterBank = rx;
    aluControl       = 3'd0;
    illegal          = 1'b0;
    if (!reset) begin
      unique case (state_q)
        StFetch: begin
          WrIR    = 1'b1;
          incr_pc = 1'b1;
        end
        StDec: begin
          if (is_alu) begin
            WrA = 1'b1;
          end else if (is_mvi) begin
            addrRegisterBank = PcAddr;
            WrAddressOut     = 1'b1;
            incr_pc          = 1'b1;
          end else if (is_ld) begin
            addrRegisterBank = ry;
            WrAddressOut     = 1'b1;
          end else if (is_sd) begin
            addrRegisterBank = ry;
            WrDataOut        = 1'b1;
          end else begin
            illegal = 1'b1;
          end
        end
        StExec: begin
          if (is_alu) begin
            addrRegisterBank = ry;
            aluControl       = opcode[2:0];
            WrG              = 1'b1;
          end else if (is_mvi || is_ld) begin
            multControl    = MuxDin;
            WrRegisterBank = 1'b1;
          end else if (is_sd) begin
            WrAddressOut = 1'b1;
            WrW          = 1'b1;
          end
        end
        StWb: begin
          multControl    = MuxAlu;
          WrRegisterBank = 1'b1;
        end
        StDone: begin
          done             = 1'b1;
          addrRegisterBank = PcAddr;
          WrAddressOut     = 1'b1;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_proc_ctrl_fsm.sv
// Scoreboard bench for proc_ctrl_fsm: stimulus pushes the hand-computed output
// vector for each cycle, a monitor pops and compares on the falling edge.
module tb_proc_ctrl_fsm;

  logic       Clock = 1'b0;
  logic       reset = 1'b1;
  logic       run = 1'b0;
  logic [9:0] data = '0;
  logic       mem_ready = 1'b0;
  logic       done, incr_pc, WrRegisterBank, WrIR, WrW, WrDataOut, WrAddressOut, WrA, WrG;
  logic [2:0] multControl, addrRegisterBank, aluControl;
  logic       illegal;

  int checks = 0;
  int errors = 0;

  logic [18:0] exp_q[$];
  string       name_q[$];

  proc_ctrl_fsm #(.DATA_W(10), .OPC_W(4), .REG_AW(3), .PC_IDX(7)) dut (
    .Clock(Clock), .reset(reset), .run(run), .data(data), .mem_ready(mem_ready),
    .done(done), .incr_pc(incr_pc), .WrRegisterBank(WrRegisterBank), .WrIR(WrIR),
    .WrW(WrW), .WrDataOut(WrDataOut), .WrAddressOut(WrAddressOut), .WrA(WrA), .WrG(WrG),
    .multControl(multControl), .addrRegisterBank(addrRegisterBank),
    .aluControl(aluControl), .illegal(illegal)
  );

  always #5 Clock = ~Clock;

  logic [18:0] act;
  assign act = {done, incr_pc, WrRegisterBank, WrIR, WrW, WrDataOut, WrAddressOut, WrA, WrG,
                multControl, addrRegisterBank, aluControl, illegal};

  // Order: done incr wrb wrir wrw wrdo wrao wra wrg | mult addr alu | illegal
  function automatic logic [18:0] ex(input bit dn, input bit ip, input bit wrb, input bit wir,
                                     input bit ww, input bit wdo, input bit wao, input bit wa,
                                     input bit wg, input logic [2:0] mult,
                                     input logic [2:0] addr, input logic [2:0] alu,
                                     input bit ill);
    return {dn, ip, wrb, wir, ww, wdo, wao, wa, wg, mult, addr, alu, ill};
  endfunction

  // One cycle: drive inputs just after the rising edge and queue the expected outputs.
  task automatic step(input logic rst, input logic r, input logic [9:0] d, input logic mr,
                      input logic [18:0] e, input string n);
    @(posedge Clock);
    #1;
    reset = rst;
    run = r;
    data = d;
    mem_ready = mr;
    exp_q.push_back(e);
    name_q.push_back(n);
  endtask

  // Monitor: one queued expectation per falling edge.
  always @(negedge Clock) begin
    if (exp_q.size() > 0) begin
      logic [18:0] e;
      string n;
      e = exp_q.pop_front();
      n = name_q.pop_front();
      checks++;
      if (act !== e) begin
        errors++;
        $display("FAIL %s: got %b required %b", n, act, e);
      end
    end
  end

  localparam logic [9:0] DAdd = 10'b0000_001_010;
  localparam logic [9:0] DLd  = 10'b1010_011_101;
  localparam logic [9:0] DIll = 10'b1101_010_001;
  localparam logic [9:0] DSub = 10'b0001_100_110;
  localparam logic [9:0] DSd  = 10'b1001_000_100;
  localparam logic [9:0] DMvi = 10'b1000_101_000;
  localparam logic [9:0] DMv  = 10'b0111_010_011;

  initial begin
    // Reset state
    step(1, 0, 10'd0, 0, ex(0,0,0,0,0,0,0,0,0, 2,0,0, 0), "reset0");
    step(1, 1, 10'd0, 0, ex(0,0,0,0,0,0,0,0,0, 2,0,0, 0), "reset1");

    // ADD R1,R2: 5 cycles
    step(0, 1, DAdd, 0, ex(0,1,0,1,0,0,0,0,0, 2,1,0, 0), "add_fetch");
    step(0, 1, DAdd, 0, ex(0,0,0,0,0,0,0,1,0, 2,1,0, 0), "add_dec");
    step(0, 1, DAdd, 0, ex(0,0,0,0,0,0,0,0,1, 2,2,0, 0), "add_exec");
    step(0, 1, DAdd, 0, ex(0,0,1,0,0,0,0,0,0, 4,1,0, 0), "add_wb");
    step(0, 1, DAdd, 0, ex(1,0,0,0,0,0,1,0,0, 2,7,0, 0), "add_done");

    // LD R3,R5: no write-back step
    step(0, 1, DLd, 0, ex(0,1,0,1,0,0,0,0,0, 2,3,0, 0), "ld_fetch");
    step(0, 1, DLd, 0, ex(0,0,0,0,0,0,1,0,0, 2,5,0, 0), "ld_dec");
    step(0, 1, DLd, 0, ex(0,0,1,0,0,0,0,0,0, 1,3,0, 0), "ld_exec");
    step(0, 1, DLd, 0, ex(1,0,0,0,0,0,1,0,0, 2,7,0, 0), "ld_done");

    // Opcode 13: flagged, no strobes, done in cycle 3
    step(0, 1, DIll, 0, ex(0,1,0,1,0,0,0,0,0, 2,2,0, 0), "ill_fetch");
    step(0, 1, DIll, 0, ex(0,0,0,0,0,0,0,0,0, 2,2,0, 1), "ill_dec");
    step(0, 1, DIll, 0, ex(1,0,0,0,0,0,1,0,0, 2,7,0, 0), "ill_done");

    // SUB R4,R6: run low in fetch and for 3 exec cycles; run low in done still returns
    step(0, 0, DSub, 0, ex(0,1,0,1,0,0,0,0,0, 2,4,0, 0), "sub_fetch_hold");
    step(0, 1, DSub, 0, ex(0,1,0,1,0,0,0,0,0, 2,4,0, 0), "sub_fetch");
    step(0, 1, DSub, 0, ex(0,0,0,0,0,0,0,1,0, 2,4,0, 0), "sub_dec");
    for (int i = 0; i < 3; i++)
      step(0, 0, DSub, 0, ex(0,0,0,0,0,0,0,0,1, 2,6,1, 0), "sub_exec_hold");
    step(0, 1, DSub, 0, ex(0,0,0,0,0,0,0,0,1, 2,6,1, 0), "sub_exec");
    step(0, 1, DSub, 0, ex(0,0,1,0,0,0,0,0,0, 4,4,0, 0), "sub_wb");
    step(0, 0, DSub, 0, ex(1,0,0,0,0,0,1,0,0, 2,7,0, 0), "sub_done_runlow");

    // SD R0,R4, mem_ready low for two exec cycles
    step(0, 1, DSd, 0, ex(0,1,0,1,0,0,0,0,0, 2,0,0, 0), "sd_fetch");
    step(0, 1, DSd, 0, ex(0,0,0,0,0,1,0,0,0, 2,4,0, 0), "sd_dec");
`ifdef CTRL_MEMWAIT_EN
    step(0, 1, DSd, 0, ex(0,0,0,0,1,0,1,0,0, 2,0,0, 0), "sd_exec_wait0");
    step(0, 1, DSd, 0, ex(0,0,0,0,1,0,1,0,0, 2,0,0, 0), "sd_exec_wait1");
    step(0, 1, DSd, 1, ex(0,0,0,0,1,0,1,0,0, 2,0,0, 0), "sd_exec");
`else
    step(0, 1, DSd, 0, ex(0,0,0,0,1,0,1,0,0, 2,0,0, 0), "sd_exec");
`endif
    step(0, 1, DSd, 0, ex(1,0,0,0,0,0,1,0,0, 2,7,0, 0), "sd_done");

    // MVI R5
    step(0, 1, DMvi, 1, ex(0,1,0,1,0,0,0,0,0, 2,5,0, 0), "mvi_fetch");
    step(0, 1, DMvi, 1, ex(0,1,0,0,0,0,1,0,0, 2,7,0, 0), "mvi_dec");
    step(0, 1, DMvi, 1, ex(0,0,1,0,0,0,0,0,0, 1,5,0, 0), "mvi_exec");
    step(0, 1, DMvi, 1, ex(1,0,0,0,0,0,1,0,0, 2,7,0, 0), "mvi_done");

    // MV R2,R3: alu code 7
    step(0, 1, DMv, 0, ex(0,1,0,1,0,0,0,0,0, 2,2,0, 0), "mv_fetch");
    step(0, 1, DMv, 0, ex(0,0,0,0,0,0,0,1,0, 2,2,0, 0), "mv_dec");
    step(0, 1, DMv, 0, ex(0,0,0,0,0,0,0,0,1, 2,3,7, 0), "mv_exec");
    step(0, 1, DMv, 0, ex(0,0,1,0,0,0,0,0,0, 4,2,0, 0), "mv_wb");
    step(0, 1, DMv, 0, ex(1,0,0,0,0,0,1,0,0, 2,7,0, 0), "mv_done");

    // ADD aborted by reset held during exec; restarts at fetch after release
    step(0, 1, DAdd, 0, ex(0,1,0,1,0,0,0,0,0, 2,1,0, 0), "rst_fetch");
    step(0, 1, DAdd, 0, ex(0,0,0,0,0,0,0,1,0, 2,1,0, 0), "rst_dec");
    step(0, 1, DAdd, 0, ex(0,0,0,0,0,0,0,0,1, 2,2,0, 0), "rst_exec");
    @(negedge Clock);
    #2 reset = 1'b1;
    step(1, 1, DAdd, 0, ex(0,0,0,0,0,0,0,0,0, 2,1,0, 0), "rst_held");
    step(0, 1, DAdd, 0, ex(0,1,0,1,0,0,0,0,0, 2,1,0, 0), "rst_release_fetch");
    step(0, 1, DAdd, 0, ex(0,0,0,0,0,0,0,1,0, 2,1,0, 0), "rst2_dec");
    step(0, 1, DAdd, 0, ex(0,0,0,0,0,0,0,0,1, 2,2,0, 0), "rst2_exec");

    // Reset pulse between edges during exec: state must already be fetch at the next edge
    @(negedge Clock);
    #2 reset = 1'b1;
    #2 reset = 1'b0;
    step(0, 1, DAdd, 0, ex(0,0,0,0,0,0,0,1,0, 2,1,0, 0), "pulse_dec");
    step(0, 1, DAdd, 0, ex(0,0,0,0,0,0,0,0,1, 2,2,0, 0), "pulse_exec");
    step(0, 1, DAdd, 0, ex(0,0,1,0,0,0,0,0,0, 4,1,0, 0), "pulse_wb");
    step(0, 1, DAdd, 0, ex(1,0,0,0,0,0,1,0,0, 2,7,0, 0), "pulse_done");

    repeat (3) @(negedge Clock);
    #1;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL drain: %0d expectations left, required 0", exp_q.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
